// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for the execute stage (DIV/DIVU/REM/REMU and *W forms).
// Define DIV_EARLY_OUT_EN to finish in one cycle whenever |dividend| < |divisor|.
module ex_div_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            start,
   input  logic            signed_op,
   input  logic            rem_sel,
   input  logic            word_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            stall_req,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t state, state_next;

   logic [CW-1:0]   count;
   logic [XLEN-1:0] rem_q, quo_q, div_q, result_q;
   logic            qneg_q, rneg_q, rsel_q, word_q, fix_q;

   logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, most_neg;
   logic            sign_a, sign_b, div_zero, overflow, early, special;
   logic [XLEN:0]   shifted, diff;
   logic            no_borrow;
   logic [XLEN-1:0] rem_step, quo_step;
   logic [XLEN-1:0] q_fix, r_fix, sel, final_res;

   // Operand preparation: word forms extend the low 32 bits, signed forms work on magnitudes.
   always_comb begin
      if (word_op) begin
         a_ext    = {{(XLEN-32){signed_op & a[31]}}, a[31:0]};
         b_ext    = {{(XLEN-32){signed_op & b[31]}}, b[31:0]};
         most_neg = {{(XLEN-31){1'b1}}, {31{1'b0}}};
      end else begin
         a_ext    = a;
         b_ext    = b;
         most_neg = {1'b1, {(XLEN-1){1'b0}}};
      end
      sign_a   = signed_op & a_ext[XLEN-1];
      sign_b   = signed_op & b_ext[XLEN-1];
      mag_a    = sign_a ? -a_ext : a_ext;
      mag_b    = sign_b ? -b_ext : b_ext;
      div_zero = (b_ext == '0);
      overflow = signed_op & (a_ext == most_neg) & (&b_ext);
`ifdef DIV_EARLY_OUT_EN
      early    = (mag_a < mag_b);
`else
      early    = 1'b0;
`endif
      special  = div_zero | overflow | early;
   end

   // One restoring step: the extra top bit of the difference is the borrow.
   always_comb begin
      shifted   = {rem_q, quo_q[XLEN-1]};
      diff      = shifted - {1'b0, div_q};
      no_borrow = ~diff[XLEN];
      rem_step  = no_borrow ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_step  = {quo_q[XLEN-2:0], no_borrow};
   end

   // Special-case results are stored already final, so fix_q disables the sign correction.
   always_comb begin
      q_fix     = (fix_q & qneg_q) ? -quo_q : quo_q;
      r_fix     = (fix_q & rneg_q) ? -rem_q : rem_q;
      sel       = rsel_q ? r_fix : q_fix;
      final_res = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
      result    = (state == DONE) ? final_res : result_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      stall_req  = 1'b0;
      done       = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (start && !flush) begin
               stall_req  = 1'b1;
               state_next = special ? DONE : CALC;
            end
         end
         CALC: begin
            stall_req = 1'b1;
            if (flush)                  state_next = IDLE;
            else if (count == CW'(1))   state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         div_q    <= '0;
         result_q <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         rsel_q   <= 1'b0;
         word_q   <= 1'b0;
         fix_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !flush) begin
                  rsel_q <= rem_sel;
                  word_q <= word_op;
                  qneg_q <= sign_a ^ sign_b;
                  rneg_q <= sign_a;
                  div_q  <= mag_b;
                  fix_q  <= 1'b0;
                  if (div_zero) begin
                     quo_q <= '1;
                     rem_q <= a_ext;
                  end else if (overflow) begin
                     quo_q <= a_ext;
                     rem_q <= '0;
                  end else if (early) begin
                     quo_q <= '0;
                     rem_q <= a_ext;
                  end else begin
                     // Word dividends sit in the upper half so they shift out first.
                     quo_q <= word_op ? (mag_a << (XLEN-32)) : mag_a;
                     rem_q <= '0;
                     fix_q <= 1'b1;
                     count <= word_op ? CW'(32) : CW'(XLEN);
                  end
               end
            end
            CALC: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               count <= count - CW'(1);
            end
            DONE: begin
               result_q <= final_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative radix-2 integer divider in the execute stage, downstream of the decode/execute pipeline register.
- Consumes the decoded divide/remainder operands held in that register.
- Asserts a stall request so the pipeline register and earlier stages hold while the divide runs.
- Returns one XLEN result and pulses done for one cycle so the instruction can advance.

Parameters:
- XLEN, 64, datapath width; word ops use the low 32 bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  abort current operation (branch mispredict or trap).
- start  input  1  EX holds a divide/remainder instruction; level, held until done.
- signed_op  input  1  1 = DIV/REM semantics, 0 = DIVU/REMU.
- rem_sel  input  1  1 = return remainder, 0 = return quotient.
- word_op  input  1  1 = *W variant on low 32 bits.
- a  input  XLEN  dividend.
- b  input  XLEN  divisor.
- stall_req  output  1  hold upstream pipeline registers.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle result-valid pulse.
- result  output  XLEN  quotient or remainder; valid while done=1.

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, busy=0, done=0, stall_req=0, result=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0: latch the operation mode.
  - Operand width N = 32 if word_op, else XLEN.
  - Word ops first sign- or zero-extend a[31:0] and b[31:0] per signed_op.
  - Take magnitudes if signed; record the quotient sign (sign(a) xor sign(b)) and the remainder sign (sign(a)).
- Special cases go IDLE -> DONE directly, so done is high 1 cycle after start:
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative N-bit value, divisor = -1): quotient = dividend; remainder = 0.
- Otherwise IDLE -> CALC with counter = N.
- CALC, one quotient bit per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor magnitude; set the quotient LSB if no borrow.
  - Decrement counter; at counter 1 go to DONE.
  - done is high exactly N+1 cycles after the start cycle: 65 for 64-bit ops, 33 for word ops.
- DONE:
  - done=1 and result driven; next state IDLE.
  - Apply the recorded signs: quotient truncates toward zero, remainder takes the dividend's sign.
  - Word ops: the 32-bit result is sign-extended from bit 31, for unsigned variants too.
  - start is ignored in DONE, because the same instruction is still present.
- stall_req (combinational) = (state==IDLE & start & ~flush) | (state==CALC). It is 0 in DONE so the instruction advances.
- busy = (state != IDLE).
- Operands a and b are sampled only in IDLE; later changes have no effect.
- flush:
  - From any state, the next state is IDLE; no done pulse; result keeps its last value.
  - flush and start in the same IDLE cycle: flush wins and nothing starts.
  - flush in DONE: done still asserts that cycle; the state still returns to IDLE.
- start while in CALC: no effect.
- Async reset mid-CALC: immediate return to reset values; no done.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in IDLE, a non-special op with unsigned magnitude |a| < |b| goes IDLE -> DONE with quotient 0 and remainder = dividend (signed, unchanged). done is high 1 cycle after start; stall_req is high 1 cycle.
- Undefined: such ops take the full N+1 cycles with identical results.

Test Plan:
- DIVU 64-bit, a=100, b=7, start held -> stall_req=1 cycles 0..64; done=1 at cycle 65 with result=14. Repeat with rem_sel=1 -> result=2.
- DIV, a=-5, b=0 -> done at cycle 1, result=0xFFFF_FFFF_FFFF_FFFF. REM -> 0xFFFF_FFFF_FFFF_FFFB.
- DIV overflow, a=0x8000_0000_0000_0000, b=-1 -> done at cycle 1, quotient=0x8000_0000_0000_0000. REM -> 0.
- DIVW, a=0x0000_0000_FFFF_FFF9, b=2, signed -> done at cycle 33, result=0xFFFF_FFFF_FFFF_FFFD. REMW -> 0xFFFF_FFFF_FFFF_FFFF. DIVUW with the same operands -> 0x0000_0000_7FFF_FFFC.
- flush at cycle 10 of a 64-bit DIVU -> busy=0 and stall_req=0 at cycle 11, no done. A new start at cycle 11 (DIVU 9/3) -> done at cycle 76, result=3.
- reset low at cycle 20 of CALC -> busy, done, stall_req and result all 0 immediately. Separately with DIV_EARLY_OUT_EN: DIVU 3/10 -> done at cycle 1, quotient 0, remainder 3.
